// File: rtl/hex_display_scan_if.sv
// Value/control inputs and static + scanned segment outputs of hex_display_scan.
// HEX_DISPLAY_PWM_EN adds the brightness input.
interface hex_display_scan_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value_in;
  logic                latch;
  logic                blank_lz;
`ifdef HEX_DISPLAY_PWM_EN
  logic [3:0]          brightness;
`endif
  logic [7*DIGITS-1:0] seg_static;
  logic [6:0]          seg_mux;
  logic [DIGITS-1:0]   dig_en;
  logic                frame_tick;

  modport master (
    output value_in, latch, blank_lz,
`ifdef HEX_DISPLAY_PWM_EN
    output brightness,
`endif
    input  seg_static, seg_mux, dig_en, frame_tick
  );

  modport slave (
    input  value_in, latch, blank_lz,
`ifdef HEX_DISPLAY_PWM_EN
    input  brightness,
`endif
    output seg_static, seg_mux, dig_en, frame_tick
  );
endinterface

// File: rtl/hex_display_scan.sv
// Hex 7-seg driver: static outputs 2 edges after latch, scanned bus updated per frame; no backpressure.
// Optional HEX_DISPLAY_PWM_EN gates dig_en with a 4-bit brightness PWM.
module hex_display_scan #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 25000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic               clk25,
  input  logic               rst_n,
  hex_display_scan_if.slave  bus
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam logic [6:0]        SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] DIG_OFF  = DIG_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [PRE_W-1:0]  PRE_TC   = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);

  logic [4*DIGITS-1:0] r_value;
  logic [4*DIGITS-1:0] r_shadow;
  logic [PRE_W-1:0]    r_pre;
  logic [IDX_W-1:0]    r_idx;
  logic [7*DIGITS-1:0] r_seg_static;
  logic [6:0]          r_seg_mux;
  logic [DIGITS-1:0]   r_dig_en;

  logic                w_pre_tc;
  logic                w_frame_tick;
  logic                w_pwm_on;
  logic [DIGITS-1:0]   w_blank_static;
  logic [DIGITS-1:0]   w_blank_shadow;
  logic [DIGITS-1:0]   w_onehot;
  logic [DIGITS-1:0]   w_dig_act;
  logic [7*DIGITS-1:0] w_seg_static;
  logic [3:0]          w_mux_nib;
  logic [6:0]          w_seg_mux;

  // Active-high font, bit 0 = segment a.
  function automatic logic [6:0] font(input logic [3:0] nib);
    case (nib)
      4'h0: font = 7'h3F;  4'h1: font = 7'h06;  4'h2: font = 7'h5B;  4'h3: font = 7'h4F;
      4'h4: font = 7'h66;  4'h5: font = 7'h6D;  4'h6: font = 7'h7D;  4'h7: font = 7'h07;
      4'h8: font = 7'h7F;  4'h9: font = 7'h6F;  4'hA: font = 7'h77;  4'hB: font = 7'h7C;
      4'hC: font = 7'h39;  4'hD: font = 7'h5E;  4'hE: font = 7'h79;  default: font = 7'h71;
    endcase
  endfunction

  // Digit 0 is never blanked so an all-zero value still shows a single 0.
  function automatic logic [DIGITS-1:0] lz_mask(input logic [4*DIGITS-1:0] v, input logic en);
    logic all_zero;
    all_zero = 1'b1;
    lz_mask  = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      all_zero   = all_zero & (v[4*k +: 4] == 4'h0);
      lz_mask[k] = en & all_zero;
    end
  endfunction

  function automatic logic [6:0] drive(input logic [3:0] nib, input logic blank);
    logic [6:0] lit;
    lit = blank ? 7'h00 : font(nib);
    drive = SEG_ACTIVE_LOW ? ~lit : lit;
  endfunction

`ifdef HEX_DISPLAY_PWM_EN
  logic [3:0] r_pwm;
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) r_pwm <= 4'd0;
    else        r_pwm <= r_pwm + 4'd1;
  end
  assign w_pwm_on = (r_pwm <= bus.brightness);
`else
  assign w_pwm_on = 1'b1;
`endif

  assign w_pre_tc       = (r_pre == PRE_TC);
  assign w_frame_tick   = w_pre_tc && (r_idx == IDX_LAST);
  assign w_blank_static = lz_mask(r_value, bus.blank_lz);
  assign w_blank_shadow = lz_mask(r_shadow, bus.blank_lz);
  assign w_mux_nib      = r_shadow[{r_idx, 2'b00} +: 4];
  assign w_seg_mux      = drive(w_mux_nib, w_blank_shadow[r_idx]);
  assign w_dig_act      = w_onehot & {DIGITS{w_pwm_on}};

  always_comb begin
    w_onehot     = '0;
    w_seg_static = '0;
    for (int k = 0; k < DIGITS; k++) begin
      w_onehot[k]          = (r_idx == IDX_W'(k));
      w_seg_static[7*k +: 7] = drive(r_value[4*k +: 4], w_blank_static[k]);
    end
  end

  // Shadow loads on the wrap edge, the same edge the index returns to 0,
  // so every frame of the scanned display comes from one value.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_value      <= '0;
      r_shadow     <= '0;
      r_pre        <= '0;
      r_idx        <= '0;
      r_seg_static <= {DIGITS{SEG_OFF}};
      r_seg_mux    <= SEG_OFF;
      r_dig_en     <= DIG_OFF;
    end else begin
      if (bus.latch)   r_value  <= bus.value_in;
      if (w_frame_tick) r_shadow <= r_value;
      r_pre <= w_pre_tc ? '0 : r_pre + 1'b1;
      if (w_pre_tc)    r_idx    <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      r_seg_static <= w_seg_static;
      r_seg_mux    <= w_seg_mux;
      r_dig_en     <= DIG_ACTIVE_LOW ? ~w_dig_act : w_dig_act;
    end
  end

  assign bus.seg_static = r_seg_static;
  assign bus.seg_mux    = r_seg_mux;
  assign bus.dig_en     = r_dig_en;
  assign bus.frame_tick = w_frame_tick;
endmodule

// File: tb/tb_hex_display_scan.sv
// Bench for hex_display_scan with DIGITS=4, SCAN_DIV=4, active-low segments and digit enables.
module tb_hex_display_scan;
  localparam logic [6:0] G0 = 7'h40, G1 = 7'h79, G2 = 7'h24, G3 = 7'h30;
  localparam logic [6:0] G4 = 7'h19, G5 = 7'h12, G6 = 7'h02, G7 = 7'h78;
  localparam logic [6:0] G8 = 7'h00, G9 = 7'h10, GA = 7'h08, GB = 7'h03;
  localparam logic [6:0] GC = 7'h46, GD = 7'h21, GE = 7'h06, GF = 7'h0E;
  localparam logic [6:0] GX = 7'h7F;

  logic clk25 = 1'b0;
  logic rst_n;
  always #5 clk25 = ~clk25;

  hex_display_scan_if #(.DIGITS(4)) bus ();

  hex_display_scan #(
    .DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk25(clk25),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [15:0] val;
    logic        lat;
    logic        blz;
    logic [27:0] exp;
  } vec_t;

  typedef struct {
    logic [3:0] dig;
    logic [6:0] seg;
    logic       tick;
  } mux_exp_t;

  vec_t        vecs[10];
  mux_exp_t    mux_q[$];
  logic [27:0] stat_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic step();
    @(posedge clk25);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_seg_static", bus.seg_static, 28'hFFFFFFF);
    check("rst_seg_mux",    bus.seg_mux,    7'h7F);
    check("rst_dig_en",     bus.dig_en,     4'hF);
    check("rst_frame_tick", bus.frame_tick, 1'b0);
  endtask

  // Called just after a posedge; edge n below is the n-th edge after release.
  task automatic release_and_check_ticks();
    int first, second, highs;
    first = 0; second = 0; highs = 0;
    bus.blank_lz = 1'b0;
    rst_n = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (n == 1) begin
        check("dig_en_slot0",    bus.dig_en,     4'hE);
        check("seg_mux_cleared", bus.seg_mux,    G0);
        check("static_cleared",  bus.seg_static, {G0, G0, G0, G0});
      end
      if (bus.frame_tick) begin
        highs++;
        if (first == 0) first = n;
        else if (second == 0) second = n;
      end
    end
    check("first_tick_edge",  first,  15);
    check("second_tick_edge", second, 31);
    check("tick_count_40",    highs,  2);
  endtask

  task automatic wait_tick();
    for (int n = 0; n < 40; n++) begin
      step();
      if (bus.frame_tick) break;
    end
    check("frame_tick_seen", bus.frame_tick, 1'b1);
  endtask

  // Called just after the shadow-load edge; checks one 16-cycle frame.
  task automatic expect_frame(input logic [27:0] g, input int latch_k, input logic [15:0] lval);
    mux_exp_t e;
    for (int d = 0; d < 4; d++) begin
      for (int r = 0; r < 4; r++) begin
        e.dig  = ~(4'b0001 << d);
        e.seg  = g[7*d +: 7];
        e.tick = (d == 3) && (r == 2);
        mux_q.push_back(e);
      end
    end
    for (int k = 1; k <= 16; k++) begin
      step();
      bus.latch = 1'b0;
      e = mux_q.pop_front();
      check($sformatf("dig_en[k=%0d]", k),     bus.dig_en,     e.dig);
      check($sformatf("seg_mux[k=%0d]", k),    bus.seg_mux,    e.seg);
      check($sformatf("frame_tick[k=%0d]", k), bus.frame_tick, e.tick);
      if (k == latch_k) begin
        bus.value_in = lval;
        bus.latch    = 1'b1;
      end
    end
  endtask

  initial begin
    int cnt;
    vecs[0] = '{16'h1A2F, 1'b1, 1'b0, {G1, GA, G2, GF}};
    vecs[1] = '{16'h5555, 1'b0, 1'b0, {G1, GA, G2, GF}};
    vecs[2] = '{16'h0030, 1'b1, 1'b1, {GX, GX, G3, G0}};
    vecs[3] = '{16'h0000, 1'b1, 1'b1, {GX, GX, GX, G0}};
    vecs[4] = '{16'hFFFF, 1'b0, 1'b0, {G0, G0, G0, G0}};
    vecs[5] = '{16'h89BC, 1'b1, 1'b1, {G8, G9, GB, GC}};
    vecs[6] = '{16'h0D0E, 1'b1, 1'b1, {GX, GD, G0, GE}};
    vecs[7] = '{16'h3000, 1'b1, 1'b1, {G3, G0, G0, G0}};
    vecs[8] = '{16'h7654, 1'b1, 1'b0, {G7, G6, G5, G4}};
    vecs[9] = '{16'h0001, 1'b1, 1'b1, {GX, GX, GX, G1}};

    rst_n        = 1'b0;
    bus.value_in = '0;
    bus.latch    = 1'b0;
    bus.blank_lz = 1'b0;
`ifdef HEX_DISPLAY_PWM_EN
    bus.brightness = 4'd15;
`endif
    repeat (3) step();
    check_reset_outputs();
    release_and_check_ticks();

    // Static path: capture edge, then decode edge; value_in is scrambled in between.
    for (int i = 0; i < 10; i++) begin
      bus.value_in = vecs[i].val;
      bus.latch    = vecs[i].lat;
      bus.blank_lz = vecs[i].blz;
      stat_q.push_back(vecs[i].exp);
      step();
      bus.latch    = 1'b0;
      bus.value_in = ~vecs[i].val;
      step();
      check($sformatf("seg_static[%0d]", i), bus.seg_static, stat_q.pop_front());
    end

    // Scanned path, including a latch on the frame_tick cycle.
    bus.blank_lz = 1'b0;
    bus.value_in = 16'h1234;
    bus.latch    = 1'b1;
    step();
    bus.latch    = 1'b0;
    wait_tick();
    step();
    expect_frame({G1, G2, G3, G4}, 15, 16'h5678);
    expect_frame({G1, G2, G3, G4}, 0, 16'h0000);
    check("static_after_tick_latch", bus.seg_static, {G5, G6, G7, G8});
    bus.blank_lz = 1'b1;
    expect_frame({G5, G6, G7, G8}, 1, 16'h0030);
    expect_frame({GX, GX, G3, G0}, 1, 16'h0000);
    expect_frame({GX, GX, GX, G0}, 0, 16'h0000);

`ifdef HEX_DISPLAY_PWM_EN
    bus.brightness = 4'd3;
    step();
    cnt = 0;
    for (int n = 0; n < 16; n++) begin
      step();
      if (bus.dig_en != 4'hF) cnt++;
    end
    check("pwm_duty_3", cnt, 4);
    bus.brightness = 4'd15;
    step();
    cnt = 0;
    for (int n = 0; n < 16; n++) begin
      step();
      if (bus.dig_en != 4'hF) cnt++;
    end
    check("pwm_duty_15", cnt, 16);
`else
    cnt = 0;
`endif

    // Asynchronous reset in the middle of a slot.
    repeat (5) step();
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    step();
    release_and_check_ticks();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
